// File: rtl/control_unit.sv
// Moore control sequencer: fetch in T0-T2 (T1 stalls on Mem_ready), execute in T3-T6, Stop halts at instruction boundary.
// Optional mul/div execution (T5 LOin, T6 HIin) is built only when CTRL_MULDIV_EN is defined.
module control_unit (
  input  logic        Clock,
  input  logic        Resetn,
  input  logic [31:0] IR,
  input  logic        Mem_ready,
  input  logic        Stop,
  output logic        PCout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        MDRout,
  output logic        HIout,
  output logic        LOout,
  output logic        MARin,
  output logic        Zin,
  output logic        PCin,
  output logic        MDRin,
  output logic        IRin,
  output logic        Yin,
  output logic        HIin,
  output logic        LOin,
  output logic        IncPC,
  output logic        Read,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic [4:0]  opcode,
  output logic        Run
);

  typedef enum logic [3:0] {
    RST  = 4'd0,
    T0   = 4'd1,
    T1   = 4'd2,
    T2   = 4'd3,
    T3   = 4'd4,
    T4   = 4'd5,
    T5   = 4'd6,
    T6   = 4'd7,
    HALT = 4'd8
  } state_t;

  state_t state_q, state_d;
  logic   t1_wait_q, t1_wait_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  logic       is_bin, is_un, is_md, is_halt;
  logic       unused_ir;

  assign op        = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  function automatic logic [15:0] onehot(input logic [3:0] idx);
    onehot = 16'h0001 << idx;
  endfunction

  always_comb begin
    is_bin  = 1'b0;
    is_un   = 1'b0;
    is_md   = 1'b0;
    is_halt = 1'b0;
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
      5'b01000, 5'b01001, 5'b01010, 5'b01011: is_bin = 1'b1;
`ifdef CTRL_MULDIV_EN
      5'b01111, 5'b10000: begin
        is_bin = 1'b1;
        is_md  = 1'b1;
      end
`endif
      5'b10001, 5'b10010: is_un   = 1'b1;
      5'b11011:           is_halt = 1'b1;
      default: ;
    endcase
  end

  // Stop is only honoured on the final state of an instruction.
  always_comb begin
    state_d   = state_q;
    t1_wait_d = 1'b0;
    case (state_q)
      RST: state_d = T0;
      T0:  state_d = T1;
      T1: begin
        t1_wait_d = !Mem_ready;
        if (Mem_ready) state_d = T2;
      end
      T2: state_d = T3;
      T3: begin
        if (is_halt)              state_d = HALT;
        else if (is_bin || is_un) state_d = T4;
        else                      state_d = Stop ? HALT : T0;
      end
      T4: state_d = T5;
      T5: begin
        if (is_md) state_d = T6;
        else       state_d = Stop ? HALT : T0;
      end
      T6:      state_d = Stop ? HALT : T0;
      HALT:    state_d = HALT;
      default: state_d = RST;
    endcase
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= RST;
      t1_wait_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      t1_wait_q <= t1_wait_d;
    end
  end

  assign HIout = 1'b0;
  assign LOout = 1'b0;
  assign Run   = Resetn && (state_q != HALT);

  always_comb begin
    PCout    = 1'b0;
    Zhighout = 1'b0;
    Zlowout  = 1'b0;
    MDRout   = 1'b0;
    MARin    = 1'b0;
    Zin      = 1'b0;
    PCin     = 1'b0;
    MDRin    = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    IncPC    = 1'b0;
    Read     = 1'b0;
    Rin      = 16'h0000;
    Rout     = 16'h0000;
    opcode   = 5'b00000;
    case (state_q)
      T0: begin
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
        Zin   = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = !t1_wait_q;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_bin) begin
          Rout = onehot(rb);
          Yin  = 1'b1;
        end
      end
      T4: begin
        Rout   = is_bin ? onehot(rc) : onehot(rb);
        opcode = op;
        Zin    = 1'b1;
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_md) LOin = 1'b1;
        else       Rin  = onehot(ra);
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port Clock, input, 1, single system clock; all state changes on rising edge.
REQ-002 SHALL have port Resetn, input, 1, asynchronous active-low reset.
REQ-003 SHALL have port IR, input, 32, instruction register: opcode IR[31:27], ra IR[26:23], rb IR[22:19], rc IR[18:15].
REQ-004 SHALL have port Mem_ready, input, 1, memory data valid during fetch read.
REQ-005 SHALL have port Stop, input, 1, request halt at next instruction boundary.
REQ-006 SHALL have ports PCout, Zhighout, Zlowout, MDRout, HIout, LOout, outputs, 1 each, bus source selects.
REQ-007 SHALL have ports MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, IncPC, Read, outputs, 1 each, register enables and controls.
REQ-008 SHALL have ports Rin and Rout, outputs, 16 each, one-hot general-register write and drive selects.
REQ-009 SHALL have port opcode, output, 5, ALU operation select.
REQ-010 SHALL have port Run, output, 1, high while not halted.

Function
REQ-011 SHALL be a Moore FSM with states RST, T0, T1, T2, T3, T4, T5, T6, HALT; outputs decoded from state and latched IR only, valid for the whole cycle.
REQ-012 SHALL assert in T0: PCout, MARin, IncPC, Zin; next state T1.
REQ-013 SHALL assert in T1: Zlowout, PCin, Read, MDRin; hold T1 while Mem_ready=0 with PCin asserted on the first T1 cycle only; advance to T2 when Mem_ready=1.
REQ-014 SHALL assert in T2: MDRout, IRin; next state T3.
REQ-015 SHALL decode opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shra, 01001 shl, 01010 ror, 01011 rol, 01111 mul, 10000 div, 10001 neg, 10010 not, 11010 nop, 11011 halt; all others treated as nop.
REQ-016 SHALL assert in T3 for binary ops: Rout[rb], Yin; unary ops (neg, not): no outputs.
REQ-017 SHALL assert in T4: Rout[rc] (binary) or Rout[rb] (unary), opcode=IR[31:27], Zin.
REQ-018 SHALL assert in T5: Zlowout with Rin[ra] for non-mul/div ALU ops, or Zlowout with LOin for mul/div.
REQ-019 SHALL assert in T6 (mul/div only): Zhighout, HIin.
REQ-020 SHALL return to T0 after final execute state; nop returns to T0 from T3; halt opcode enters HALT from T3.
REQ-021 SHALL sample Stop at the last state of each instruction; Stop=1 enters HALT instead of T0.
REQ-022 SHALL remain in HALT with all controls 0 and Run=0 until reset.
REQ-023 SHALL keep opcode output 00000 outside T4.
REQ-024 SHALL drive Rin/Rout with at most one bit set; register field 0..15 maps to bit index.

Reset
REQ-025 SHALL on Resetn=0 immediately force state RST and all outputs 0, including mid-instruction and mid-wait.
REQ-026 SHALL leave RST to T0 on first rising edge after Resetn deasserts; Run=1 in RST.

Configuration
REQ-027 SHALL with macro CTRL_MULDIV_EN defined, execute mul/div per REQ-018/019.
REQ-028 SHALL with CTRL_MULDIV_EN undefined, treat 01111 and 10000 as nop; T6 unreachable.

Verification
REQ-029 SHALL check: IR=0x28918000 (and R1,R2,R3), Mem_ready=1 -> T3 Rout=0x0004 Yin; T4 Rout=0x0008 opcode=00101 Zin; T5 Rin=0x0002 Zlowout; back to T0; six cycles total.
REQ-030 SHALL check: IR=0x4A918000 (shl R5,R2,R3) -> T4 opcode=01001; T5 Rin=0x0020.
REQ-031 SHALL check: Mem_ready low 3 cycles in T1 -> Read/MDRin held 4 cycles, PCin single cycle, IRin once.
REQ-032 SHALL check: IR=0x78918000 (mul) with CTRL_MULDIV_EN -> T5 LOin, T6 HIin, no Rin; without macro -> no Zin, back to T0 after T3.
REQ-033 SHALL check: Stop=1 during T4 of add -> HALT after T5, Run=0; IR opcode 11011 -> HALT after T3.
REQ-034 SHALL check: Resetn low during T4 -> all outputs 0 same cycle, T0 on first edge after release.
